// File: rtl/mode_led_blinker_pkg.sv
// Board-wide constants for the blink-code LED driver, plus a small helper
// that sizes the tick counter from the longest interval.
package mode_led_blinker_pkg;

    localparam int CLK_HZ            = 27_000_000;
    localparam int DEF_TICKS_ON      = 2_700_000;
    localparam int DEF_TICKS_OFF     = 5_400_000;
    localparam int DEF_TICKS_GAP     = 21_600_000;
    localparam int DEF_CODE_W        = 4;
    localparam int DEF_LED_ACTIVE_LO = 1;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/mode_led_blinker_interval_counter.sv
// Tick counter that runs 0..i_last, flags the terminal cycle and wraps to 0;
// i_clr restarts it from 0 on the next cycle.
module mode_led_blinker_interval_counter #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic [W-1:0] i_last,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;

    assign o_tc = (r_cnt == i_last);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr || o_tc) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mode_led_blinker.sv
// Shows a small value on one LED as N short blinks followed by a long dark
// gap, repeating; i_load restarts the frame at once with the current i_code.
module mode_led_blinker
    import mode_led_blinker_pkg::*;
#(
    parameter int TICKS_ON       = DEF_TICKS_ON,
    parameter int TICKS_OFF      = DEF_TICKS_OFF,
    parameter int TICKS_GAP      = DEF_TICKS_GAP,
    parameter int CODE_W         = DEF_CODE_W,
    parameter int LED_ACTIVE_LOW = DEF_LED_ACTIVE_LO
) (
    input  logic              CK,
    input  logic              RST,
    input  logic [CODE_W-1:0] i_code,
    input  logic              i_load,
    output logic              o_led,
    output logic              o_busy,
    output logic              o_frame
);

    localparam int CNT_W = $clog2(max3(TICKS_ON, TICKS_OFF, TICKS_GAP) + 1);
    localparam logic [CNT_W-1:0] LAST_ON  = CNT_W'(TICKS_ON - 1);
    localparam logic [CNT_W-1:0] LAST_OFF = CNT_W'(TICKS_OFF - 1);
    localparam logic [CNT_W-1:0] LAST_GAP = CNT_W'(TICKS_GAP - 1);
    localparam logic             LED_INV  = (LED_ACTIVE_LOW != 0);

    typedef enum logic [1:0] {
        ST_GAP = 2'd0,
        ST_ON  = 2'd1,
        ST_OFF = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [CODE_W-1:0] r_rem, w_rem_nxt;
    logic              r_frame, w_frame_nxt;
    logic [CNT_W-1:0]  w_last;
    logic              w_tc;

    always_comb begin
        case (r_state)
            ST_ON:   w_last = LAST_ON;
            ST_OFF:  w_last = LAST_OFF;
            default: w_last = LAST_GAP;
        endcase
    end

    mode_led_blinker_interval_counter #(.W(CNT_W)) u_cnt (
        .i_clk  (CK),
        .i_rst  (RST),
        .i_clr  (i_load),
        .i_last (w_last),
        .o_tc   (w_tc)
    );

    // A load behaves exactly like the end of a gap: sample the code and
    // start a new frame, dark again if the code is zero.
    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_frame_nxt = 1'b0;
        if (i_load || (w_tc && (r_state == ST_GAP))) begin
            w_frame_nxt = 1'b1;
            w_rem_nxt   = i_code;
            w_state_nxt = (i_code == '0) ? ST_GAP : ST_ON;
        end else if (w_tc) begin
            case (r_state)
                ST_ON: w_state_nxt = ST_OFF;
                ST_OFF: begin
                    if (r_rem == CODE_W'(1)) begin
                        w_state_nxt = ST_GAP;
                    end else begin
                        w_rem_nxt   = r_rem - 1'b1;
                        w_state_nxt = ST_ON;
                    end
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            r_state <= ST_GAP;
            r_rem   <= '0;
            r_frame <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
            r_frame <= w_frame_nxt;
        end
    end

    assign o_led   = (r_state == ST_ON) ^ LED_INV;
    assign o_busy  = (r_state == ST_ON) || (r_state == ST_OFF);
    assign o_frame = r_frame;

endmodule

// File: tb/tb_mode_led_blinker.sv
// Bench for mode_led_blinker with short tick values: a frame-timeline model
// predicts {led, busy, frame} for every cycle and a monitor compares them.
module tb_mode_led_blinker;

  localparam int T_ON      = 3;
  localparam int T_OFF     = 2;
  localparam int T_GAP     = 5;
  localparam int CW        = 4;
  localparam int W         = 3;
  localparam int MAX_CYCLES = 5000;

  logic          CK = 1'b0;
  logic          RST = 1'b1;
  logic [CW-1:0] i_code = '0;
  logic          i_load = 1'b0;
  logic          o_led, o_busy, o_frame;

  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  fr_q[$];
  int            n_checks = 0;
  int            n_pass   = 0;
  int            cyc      = 0;
  logic          done     = 1'b0;

  mode_led_blinker #(
    .TICKS_ON       (T_ON),
    .TICKS_OFF      (T_OFF),
    .TICKS_GAP      (T_GAP),
    .CODE_W         (CW),
    .LED_ACTIVE_LOW (0)
  ) dut (
    .CK      (CK),
    .RST     (RST),
    .i_code  (i_code),
    .i_load  (i_load),
    .o_led   (o_led),
    .o_busy  (o_busy),
    .o_frame (o_frame)
  );

  // clock / reset
  always #5 CK = ~CK;

  // Expected output timeline of one frame: N blinks of (lit ON, dark OFF)
  // then a dark gap; the frame flag marks its first cycle.
  task automatic build_frame(input logic [CW-1:0] code, input logic pulse);
    fr_q.delete();
    for (int b = 0; b < int'(code); b++) begin
      for (int k = 0; k < T_ON; k++)  fr_q.push_back(3'b110);
      for (int k = 0; k < T_OFF; k++) fr_q.push_back(3'b010);
    end
    for (int k = 0; k < T_GAP; k++) fr_q.push_back(3'b000);
    if (pulse) fr_q[0][0] = 1'b1;
  endtask

  // Driver: apply inputs for one cycle, advance the model at the edge,
  // and queue what the DUT must show during the following cycle.
  task automatic step(input logic rst, input logic load, input logic [CW-1:0] code);
    RST    = rst;
    i_load = load;
    i_code = code;
    @(posedge CK);
    if (rst) begin
      build_frame('0, 1'b0);
    end else if (load) begin
      build_frame(code, 1'b1);
    end else begin
      void'(fr_q.pop_front());
      if (fr_q.size() == 0) build_frame(code, 1'b1);
    end
    exp_q.push_back(fr_q[0]);
    #2;
  endtask

  // Immediate check of the outputs against a fixed expectation
  task automatic check_now(input logic [W-1:0] e, input string what);
    logic [W-1:0] a;
    a = {o_led, o_busy, o_frame};
    n_checks++;
    if (a === e) n_pass++;
    else $display("FAIL %s got %b expected %b", what, a, e);
  endtask

  // Scoreboard monitor
  always @(negedge CK) begin
    cyc <= cyc + 1;
    if (exp_q.size() > 0) begin
      logic [W-1:0] e, a;
      e = exp_q.pop_front();
      a = {o_led, o_busy, o_frame};
      n_checks++;
      if (a === e) n_pass++;
      else $display("FAIL led_busy_frame cycle %0d got %b expected %b", cyc, a, e);
    end
  end

  // Watchdog: the stimulus must complete within the cycle budget
  initial begin
    repeat (MAX_CYCLES) @(posedge CK);
    if (!done) begin
      n_checks++;
      $display("FAIL watchdog: stimulus did not finish within %0d cycles", MAX_CYCLES);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
    end
  end

  initial begin
    logic [CW-1:0] code;
    // reset and idle with code 2: dark 5, then 2 blinks, period 15
    step(1'b1, 1'b0, 4'd2);
    check_now(3'b000, "reset_state");
    step(1'b1, 1'b0, 4'd2);
    repeat (45) step(1'b0, 1'b0, 4'd2);
    // code 0: always dark, frame pulse every 5
    repeat (20) step(1'b0, 1'b0, 4'd0);
    // maximum code: 15 blinks, period 80
    repeat (170) step(1'b0, 1'b0, 4'd15);
    // code 1 frame, load with code 3 while in OFF
    step(1'b1, 1'b0, 4'd1);
    repeat (9) step(1'b0, 1'b0, 4'd1);
    step(1'b0, 1'b1, 4'd3);
    repeat (40) step(1'b0, 1'b0, 4'd0);
    // code change 2 -> 4 mid-frame without load
    step(1'b0, 1'b1, 4'd2);
    repeat (6) step(1'b0, 1'b0, 4'd2);
    repeat (50) step(1'b0, 1'b0, 4'd4);
    // load held high: stuck at ON start with frame high
    repeat (6) step(1'b0, 1'b1, 4'd5);
    // reset together with load while lit
    step(1'b0, 1'b0, 4'd5);
    step(1'b1, 1'b1, 4'd5);
    check_now(3'b000, "reset_over_load");
    repeat (8) step(1'b0, 1'b0, 4'd1);
    // load landing on a gap-terminal cycle
    step(1'b1, 1'b0, 4'd0);
    repeat (4) step(1'b0, 1'b0, 4'd0);
    step(1'b0, 1'b1, 4'd2);
    repeat (20) step(1'b0, 1'b0, 4'd0);
    // randomized mix
    code = 4'($urandom_range(0, 15));
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 29) == 0) code = 4'($urandom_range(0, 15));
      step(($urandom_range(0, 149) == 0), ($urandom_range(0, 39) == 0), code);
    end
    @(negedge CK);
    @(negedge CK);
    done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    if (n_pass == n_checks) $display("PASS");
    else $display("FAIL %0d mismatches", n_checks - n_pass);
    $finish;
  end

endmodule
